// File: rtl/xw_updown_counter.sv
// rtl/xw_updown_counter.sv - synchronous up/down counter with parallel load and active-low cascade carry
//
// Purpose:
//   Binary up/down counter in the style of a 74x169, widened to WIDTH bits.
//   It counts up or down modulo 2^WIDTH and has a synchronous parallel load.
//   Two active-low enables are provided: ENP_L (parallel) and ENT_L
//   (trickle/cascade). RCO_L flags the terminal count in the current
//   direction, so chaining RCO_L -> ENT_L builds wider counters.
//
// Ports:
//   CLK    in   clock; all state changes on the rising edge
//   CLR    in   asynchronous clear, active-high; forces Q to 0
//   LD_L   in   synchronous parallel load, active-low; highest clocked priority
//   UP     in   direction: 1 = count up, 0 = count down
//   ENP_L  in   count enable (parallel), active-low
//   ENT_L  in   count enable (trickle), active-low; also gates RCO_L
//   D      in   parallel load data [WIDTH]
//   Q      out  registered count [WIDTH]
//   RCO_L  out  ripple carry/borrow, active-low, combinational from Q/UP/ENT_L

module xw_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LD_L,
  input  logic             UP,
  input  logic             ENP_L,
  input  logic             ENT_L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO_L
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             count_en;
  logic             term_up;
  logic             term_dn;

  // Both enables must be asserted (low) for a count step.
  assign count_en = ~ENP_L & ~ENT_L;

  // Next-state: load beats counting; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (!LD_L) begin
      q_d = D;
    end else if (count_en) begin
      if (UP) begin
        q_d = q_q + WIDTH'(1);
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end
  end

  // Clear is asynchronous, so it also overrides a coincident clock edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Terminal count depends on direction: all-ones going up, zero going down.
  // ENP_L is deliberately left out so a held stage still reports carry to
  // the next stage, matching the classic cascade arrangement.
  assign term_up = &q_q;
  assign term_dn = ~|q_q;
  assign RCO_L   = ~(~ENT_L & (UP ? term_up : term_dn));

  assign Q = q_q;

endmodule

// File: doc/xw_updown_counter.md
Name: xw_updown_counter

Overview:
- Synchronous binary up/down counter with parallel load and active-low cascade enables/carry, equivalent to a 74x169 widened by parameter.
- Counts down (borrow direction) as well as up, so it can serve as a programmable down-divider, e.g. load N and count to terminal count.
- Cascades with itself and with the team's up-only 74x163-style counters: RCO_L of a stage drives ENT_L of the next.

Parameters:
WIDTH, 4, counter width in bits (≥2)

Ports:
CLK  input  1  clock; all state changes on rising edge
CLR  input  1  asynchronous reset, active-high
LD_L  input  1  synchronous parallel load, active-low
UP  input  1  direction: 1 = count up, 0 = count down
ENP_L  input  1  count enable (parallel), active-low
ENT_L  input  1  count enable (trickle/cascade), active-low; also gates RCO_L
D  input  WIDTH  parallel load data
Q  output  WIDTH  registered count
RCO_L  output  1  ripple carry/borrow out, active-low, combinational

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (CLR); only Q is state.
- CLR=1: Q forced to 0 immediately, independent of CLK. It holds while CLR=1.
- Release of CLR: takes effect at the first rising CLK edge with CLR=0. No clock-edge activity occurs while CLR=1.
- Rising CLK edge with CLR=0, priority order:
  1. LD_L=0: Q <= D. Load ignores ENP_L, ENT_L and UP.
  2. LD_L=1, ENP_L=0, ENT_L=0: if UP=1, Q <= Q+1; if UP=0, Q <= Q-1. Arithmetic is modulo 2^WIDTH.
  3. Otherwise: Q holds.
- Wrap-around:
  - Up from all-ones gives 0.
  - Down from 0 gives all-ones.
  - There is no saturation and no sticky flag.
- RCO_L is purely combinational from Q, UP and ENT_L, with no clock latency:
  - RCO_L = 0 iff ENT_L=0 and ((UP=1 and Q=all-ones) or (UP=0 and Q=0)).
  - Otherwise RCO_L = 1.
- RCO_L does NOT depend on ENP_L or LD_L.
- RCO_L during reset: with CLR=1 (Q=0), RCO_L=0 when UP=0 and ENT_L=0, else 1.
- A UP change takes effect on RCO_L immediately and on counting at the next edge.
- Counting latency: Q reflects a load or count one CLK edge after the controlling inputs are sampled.
- Cascade rule:
  - Stage k+1 ENT_L is driven by stage k RCO_L; all stages share CLK, ENP_L, UP, LD_L and CLR.
  - The upper stage steps only on the edge where the lower stage wraps.
- Simultaneous events:
  - CLR asserted at the same time as a CLK edge: reset wins.
  - LD_L=0 together with active enables: load wins.
- Reset mid-count: Q goes to 0 asynchronously and the count resumes from 0 after CLR is released.
- Inputs are sampled with setup to CLK. No glitch filtering of RCO_L is provided; downstream logic must sample it synchronously.
- Synthesizable: one always block for Q with async CLR in the sensitivity list, and a continuous assign for RCO_L. No latches.

Test Plan:
1. Async reset: Q=4'hA, pulse CLR between edges → Q=0 before the next edge. With CLR=1 held, 3 CLK edges with enables active → Q stays 0.
2. Load priority: LD_L=0, D=4'h6, ENP_L=ENT_L=0, UP=1 → Q=6 after one edge. Then LD_L=1 → 7, 8 on successive edges.
3. Up wrap and carry:
   - Load 4'hE, UP=1, enables 0: Q sequence E, F, 0.
   - RCO_L=0 only while Q=F.
   - Set ENT_L=1 at Q=F → RCO_L=1 and Q holds.
4. Down wrap and borrow:
   - Load 4'h2, UP=0: Q sequence 2, 1, 0, F.
   - RCO_L=0 only while Q=0.
   - Toggle UP to 1 at Q=0 → RCO_L=1 immediately.
5. Hold: ENP_L=1, ENT_L=0, Q=5 → Q stays 5 over 4 edges and RCO_L=1. Then set Q=F, UP=1 → RCO_L=0 despite ENP_L=1.
6. Two-stage cascade (WIDTH=4, 8-bit total):
   - Load 8'h0F, UP=1 → next edge 8'h10.
   - Load 8'h00, UP=0 → next edge 8'hFF, with the upper stage stepping only on the lower stage's borrow edge.
